// File: rtl/serial_deser_pkg.sv
// Shared types and elaboration-time helpers for the serial_deser DDR deserializer.
package serial_deser_pkg;

  typedef enum logic {StHunt = 1'b0, StLock = 1'b1} state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic int unsigned frame_cyc(input int unsigned word_w);
    return word_w / 2;
  endfunction

endpackage

// File: rtl/serial_deser_if.sv
// Bundle of PHY-side inputs and consumer-side outputs of serial_deser.
// BITSLIP exists only when SERIAL_DESER_BITSLIP_EN is defined.
interface serial_deser_if #(
  parameter int unsigned LANES  = 1,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ERR_W  = 8
) ();
  logic                    CLKF_DATA;
  logic [2*LANES-1:0]      DIN_DDR;
  logic [LANES*WORD_W-1:0] DOUT;
  logic                    DOUT_VALID;
  logic                    LOCKED;
  logic                    FRAME_ERR;
  logic [ERR_W-1:0]        ERR_CNT;

`ifdef SERIAL_DESER_BITSLIP_EN
  logic [LANES-1:0]        BITSLIP;

  modport master (
    output CLKF_DATA, DIN_DDR, BITSLIP,
    input  DOUT, DOUT_VALID, LOCKED, FRAME_ERR, ERR_CNT
  );
  modport slave (
    input  CLKF_DATA, DIN_DDR, BITSLIP,
    output DOUT, DOUT_VALID, LOCKED, FRAME_ERR, ERR_CNT
  );
`else
  modport master (
    output CLKF_DATA, DIN_DDR,
    input  DOUT, DOUT_VALID, LOCKED, FRAME_ERR, ERR_CNT
  );
  modport slave (
    input  CLKF_DATA, DIN_DDR,
    output DOUT, DOUT_VALID, LOCKED, FRAME_ERR, ERR_CNT
  );
`endif

endinterface

// File: rtl/serial_deser_lane.sv
// One deserializer lane: shifts in an IDDR bit pair per CLKS cycle.
// With SERIAL_DESER_BITSLIP_EN a toggled half-cycle slip re-pairs late_d1 with early.
module serial_deser_lane #(
  parameter int unsigned WORD_W = 32
) (
  input  logic              CLKS,
  input  logic              RSTXS,
  input  logic [1:0]        din,      // [1] earlier bit, [0] later bit
`ifdef SERIAL_DESER_BITSLIP_EN
  input  logic              bitslip,
`endif
  output logic [WORD_W-1:0] shift
);

  logic [WORD_W-1:0] shift_q;
  logic [1:0]        pair;

`ifdef SERIAL_DESER_BITSLIP_EN
  logic slip_q;
  logic late_d1_q;

  always_ff @(posedge CLKS or negedge RSTXS) begin
    if (!RSTXS) begin
      slip_q    <= 1'b0;
      late_d1_q <= 1'b0;
    end else begin
      slip_q    <= slip_q ^ bitslip;
      late_d1_q <= din[0];
    end
  end

  // Slipped pairing: previous cycle's late bit becomes the older bit of this pair.
  assign pair = slip_q ? {late_d1_q, din[1]} : din;
`else
  assign pair = din;
`endif

  always_ff @(posedge CLKS or negedge RSTXS) begin
    if (!RSTXS) begin
      shift_q <= '0;
    end else begin
      shift_q <= {shift_q[WORD_W-3:0], pair};
    end
  end

  assign shift = shift_q;

endmodule

// File: rtl/serial_deser.sv
// Multi-lane DDR deserializer with frame-strobe capture, framing check, lock FSM and
// saturating error counter. Optional per-lane bit slip via SERIAL_DESER_BITSLIP_EN.
module serial_deser
  import serial_deser_pkg::*;
#(
  parameter int unsigned LANES       = 1,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_CNT    = 4,
  parameter int unsigned LOSS_CNT    = 3,
  parameter int unsigned ERR_W       = 8
) (
  input  logic           CLKS,
  input  logic           RSTXS,
  serial_deser_if.slave  bus
);

  localparam int unsigned FrameCyc   = frame_cyc(WORD_W);
  // One spare bit so the reset-saturated value never equals the timeout value.
  localparam int unsigned CntW       = clog2(2 * FrameCyc) + 1;
  localparam int unsigned TimeoutVal = 2 * FrameCyc - 1;
  localparam int unsigned GoodW      = clog2(LOCK_CNT + 1);
  localparam int unsigned BadW       = clog2(LOSS_CNT + 1);
  localparam logic [CntW-1:0] CntMax = '1;

  logic [LANES*WORD_W-1:0] lane_words;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    serial_deser_lane #(
      .WORD_W (WORD_W)
    ) u_lane (
      .CLKS    (CLKS),
      .RSTXS   (RSTXS),
      .din     (bus.DIN_DDR[2*l +: 2]),
`ifdef SERIAL_DESER_BITSLIP_EN
      .bitslip (bus.BITSLIP[l]),
`endif
      .shift   (lane_words[l*WORD_W +: WORD_W])
    );
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   fe;

  always_ff @(posedge CLKS or negedge RSTXS) begin
    if (!RSTXS) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(bus.CLKF_DATA);
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign fe = prev_q & ~sync_q[SYNC_STAGES-1];

  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    timeout, good, bad;
  state_e                  state_q, state_d;
  logic [GoodW-1:0]        good_cnt_q, good_cnt_d;
  logic [BadW-1:0]         bad_cnt_q, bad_cnt_d;
  logic [ERR_W-1:0]        err_cnt_q, err_cnt_d;
  logic [LANES*WORD_W-1:0] dout_q, dout_d;
  logic                    valid_q, valid_d;
  logic                    ferr_q, ferr_d;

  // A strobe in the same cycle as the timeout wins and is judged on its interval.
  assign timeout = (cnt_q == CntW'(TimeoutVal)) && !fe;
  assign good    = fe && (cnt_q == CntW'(FrameCyc - 1));
  assign bad     = (fe && !good) || timeout;

  always_comb begin
    cnt_d = cnt_q;
    if (fe || timeout) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    err_cnt_d  = err_cnt_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    dout_d     = fe ? lane_words : dout_q;

    unique case (state_q)
      StHunt: begin
        if (good) begin
          if (good_cnt_q == GoodW'(LOCK_CNT - 1)) begin
            state_d    = StLock;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + GoodW'(1);
          end
        end else if (bad) begin
          good_cnt_d = '0;
        end
      end
      StLock: begin
        if (good) begin
          valid_d   = 1'b1;
          bad_cnt_d = '0;
        end else if (bad) begin
          ferr_d = 1'b1;
          if (err_cnt_q != {ERR_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
          end
          if (bad_cnt_q == BadW'(LOSS_CNT - 1)) begin
            state_d   = StHunt;
            bad_cnt_d = '0;
          end else begin
            bad_cnt_d = bad_cnt_q + BadW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLKS or negedge RSTXS) begin
    if (!RSTXS) begin
      cnt_q      <= CntMax;
      state_q    <= StHunt;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      err_cnt_q  <= '0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      err_cnt_q  <= err_cnt_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  assign bus.DOUT       = dout_q;
  assign bus.DOUT_VALID = valid_q;
  assign bus.LOCKED     = (state_q == StLock);
  assign bus.FRAME_ERR  = ferr_q;
  assign bus.ERR_CNT    = err_cnt_q;

endmodule

// File: tb/tb_serial_deser.sv
// Directed bench for serial_deser: a 1x32 instance (framing, lock, timeout, reset, slip)
// and a 4x8 instance with ERR_W=2 (multi-lane mapping, error-count saturation).
module tb_serial_deser;

  logic CLKS  = 1'b0;
  logic RSTXS = 1'b0;
  always #5 CLKS = ~CLKS;

  serial_deser_if #(.LANES(1), .WORD_W(32), .ERR_W(8)) ia ();
  serial_deser_if #(.LANES(4), .WORD_W(8),  .ERR_W(2)) ib ();

  serial_deser #(
    .LANES(1), .WORD_W(32), .SYNC_STAGES(2), .LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(8)
  ) u_dut_a (
    .CLKS  (CLKS),
    .RSTXS (RSTXS),
    .bus   (ia)
  );

  serial_deser #(
    .LANES(4), .WORD_W(8), .SYNC_STAGES(2), .LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(2)
  ) u_dut_b (
    .CLKS  (CLKS),
    .RSTXS (RSTXS),
    .bus   (ib)
  );

  int n_chk = 0;
  int n_err = 0;
  int vld_a = 0, ferr_a = 0, vld_b = 0, ferr_b = 0;
  logic [31:0] wa [9];
  localparam logic [31:0] BWords = 32'h00FF3CA5;
`ifdef SERIAL_DESER_BITSLIP_EN
  bit slip_req = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge CLKS) begin
    if (ia.DOUT_VALID) vld_a  <= vld_a + 1;
    if (ia.FRAME_ERR)  ferr_a <= ferr_a + 1;
    if (ib.DOUT_VALID) vld_b  <= vld_b + 1;
    if (ib.FRAME_ERR)  ferr_b <= ferr_b + 1;
  end

  // Strobe low for the last two cycles; the word lands in DOUT at the next frame's first edge.
  task automatic frame_a(input logic [31:0] w, input logic [31:0] wn, input int len,
                         input bit skew);
    logic [31:0] s;
    s = skew ? {w[30:0], wn[31]} : w;
    for (int c = 0; c < len; c++) begin
      @(negedge CLKS);
      ia.CLKF_DATA = (c < len - 2);
      ia.DIN_DDR   = {s[31-2*c], s[30-2*c]};
`ifdef SERIAL_DESER_BITSLIP_EN
      ia.BITSLIP = slip_req;
      slip_req   = 1'b0;
`endif
    end
  endtask

  task automatic frame_b(input int len);
    logic [31:0] bw;
    bw = BWords;
    for (int c = 0; c < len; c++) begin
      @(negedge CLKS);
      ib.CLKF_DATA = (c < len - 2);
      for (int l = 0; l < 4; l++) begin
        ib.DIN_DDR[2*l +: 2] = {bw[l*8 + 7 - 2*c], bw[l*8 + 6 - 2*c]};
      end
    end
  endtask

  task automatic idle_a(input int n);
    repeat (n) begin
      @(negedge CLKS);
      ia.CLKF_DATA = 1'b1;
      ia.DIN_DDR   = '0;
    end
  endtask

  initial begin
    ia.CLKF_DATA = 1'b1;
    ia.DIN_DDR   = '0;
    ib.CLKF_DATA = 1'b1;
    ib.DIN_DDR   = '0;
`ifdef SERIAL_DESER_BITSLIP_EN
    ia.BITSLIP = '0;
`endif
    wa = '{32'hDEADBEEF, 32'h12345678, 32'hA5C3_0F96, 32'h8000_0001, 32'h7FFF_FFFE,
           32'hC001_D00D, 32'h0F0F_3C3C, 32'h9ABC_DEF0, 32'h5555_AAAA};

    repeat (3) @(negedge CLKS);
    #1;
    check("rst_dout",   ia.DOUT, 0);
    check("rst_valid",  ia.DOUT_VALID, 0);
    check("rst_locked", ia.LOCKED, 0);
    check("rst_ferr",   ia.FRAME_ERR, 0);
    check("rst_errcnt", ia.ERR_CNT, 0);
    check("rst_b_dout", ib.DOUT, 0);
    check("rst_b_lock", ib.LOCKED, 0);
    @(negedge CLKS);
    RSTXS = 1'b1;

    // Nominal framing: first strobe is bad, lock on the 5th, first valid on the 6th.
    for (int i = 0; i < 8; i++) begin
      frame_a(wa[i], wa[i+1], 16, 1'b0);
      #1;
      if (i >= 1) check("t1_dout", ia.DOUT, wa[i-1]);
      if (i == 4) check("t1_lock_fe4", ia.LOCKED, 0);
      if (i == 5) check("t1_lock_fe5", ia.LOCKED, 1);
      if (i == 5) check("t1_vld_fe5", vld_a, 0);
      if (i == 7) check("t1_vld_fe7", vld_a, 2);
    end
    check("t1_errcnt", ia.ERR_CNT, 0);
    check("t1_ferr",   ferr_a, 0);

    // One short (15-cycle) frame while locked.
    frame_a(wa[0], wa[1], 15, 1'b0);
    frame_a(wa[1], wa[2], 16, 1'b0);
    frame_a(wa[2], wa[3], 16, 1'b0);
    #1;
    check("t2_ferr",   ferr_a, 1);
    check("t2_errcnt", ia.ERR_CNT, 1);
    check("t2_locked", ia.LOCKED, 1);
    check("t2_vld",    vld_a, 4);
    check("t2_dout",   ia.DOUT, wa[1]);

    // Strobe stops: timeouts 31, 63, 95 cycles after the last good strobe.
    idle_a(70);
    #1;
    check("t3_ferr_2",   ferr_a, 3);
    check("t3_locked_2", ia.LOCKED, 1);
    check("t3_vld",      vld_a, 5);
    idle_a(40);
    #1;
    check("t3_ferr_3",   ferr_a, 4);
    check("t3_locked_3", ia.LOCKED, 0);
    check("t3_errcnt",   ia.ERR_CNT, 4);

    // Asynchronous reset between clock edges.
    #2 RSTXS = 1'b0;
    #1;
    check("mrst_dout",   ia.DOUT, 0);
    check("mrst_valid",  ia.DOUT_VALID, 0);
    check("mrst_locked", ia.LOCKED, 0);
    check("mrst_ferr",   ia.FRAME_ERR, 0);
    check("mrst_errcnt", ia.ERR_CNT, 0);
    repeat (3) @(negedge CLKS);
    RSTXS = 1'b1;
    for (int i = 0; i < 6; i++) begin
      frame_a(wa[i], wa[i+1], 16, 1'b0);
      #1;
      if (i == 4) check("mrst_lock_fe4", ia.LOCKED, 0);
      if (i == 5) check("mrst_lock_fe5", ia.LOCKED, 1);
    end
    check("mrst_errcnt_after", ia.ERR_CNT, 0);

`ifdef SERIAL_DESER_BITSLIP_EN
    // Stream one bit early in the pair; slip pulse on frame 1, frame 2 captures clean.
    frame_a(wa[0], wa[1], 16, 1'b1);
    slip_req = 1'b1;
    frame_a(wa[1], wa[2], 16, 1'b1);
    frame_a(wa[2], wa[3], 16, 1'b1);
    frame_a(wa[3], wa[4], 16, 1'b1);
    #1;
    check("slip_dout_f2", ia.DOUT, wa[2]);
    frame_a(wa[4], wa[5], 16, 1'b1);
    #1;
    check("slip_dout_f3", ia.DOUT, wa[3]);
    check("slip_locked",  ia.LOCKED, 1);
`endif

    // Four lanes, 8-bit words.
    for (int i = 0; i < 7; i++) begin
      frame_b(4);
      #1;
      if (i == 1) check("b_dout_hunt", ib.DOUT, 32'h00FF3CA5);
      if (i == 4) check("b_lock_fe4", ib.LOCKED, 0);
      if (i == 5) check("b_lock_fe5", ib.LOCKED, 1);
      if (i == 6) check("b_vld", vld_b, 1);
      if (i == 6) check("b_dout", ib.DOUT, 32'h00FF3CA5);
    end

    // Five isolated short frames while locked; 2-bit ERR_CNT saturates at 3.
    for (int g = 0; g < 5; g++) begin
      frame_b(3);
      frame_b(4);
      frame_b(4);
      #1;
      if (g == 1) check("b_errcnt_2", ib.ERR_CNT, 2);
    end
    check("b_errcnt_sat", ib.ERR_CNT, 3);
    check("b_ferr",       ferr_b, 5);
    check("b_locked",     ib.LOCKED, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
